vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 173 +++++++++++++++++
 tb/tb_vga_capture.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
`timescale 1ns/1ps
`default_nettype none
// vga_capture: locks onto VGA hsync/vsync timing and emits captured active pixels
// with x/y coordinates, a frame-start pulse and a saturating timing-error count.
module vga_capture #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0] HT   = 10'(H_TOTAL);
  localparam logic [9:0] HT1  = 10'(H_TOTAL - 1);
  localparam logic [9:0] HSW  = 10'(H_SYNC);
  localparam logic [9:0] HA0  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA1  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] VT   = 10'(V_TOTAL);
  localparam logic [9:0] VT1  = 10'(V_TOTAL - 1);
  localparam logic [9:0] VA0  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA1  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state, next_state;

  logic        s1_hs, s1_vs, s2_hs;
  logic [11:0] s1_rgb;
  logic [9:0]  h_cnt, h_prev, v_cnt;
  logic        vs_last;

  logic        fall_pending, hs_fall, hs_rise, boundary;
  logic        h_reach, v_reach, line_err, frame_err, err;
  logic        h_act, v_act, active;

  logic        dec_valid;
  logic [9:0]  dec_x, dec_y;
  logic [11:0] dec_rgb;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_rgb <= '0;
      s2_hs  <= 1'b1;
    end else begin
      s1_hs  <= hsync;
      s1_vs  <= vsync;
      s1_rgb <= {vga_r, vga_g, vga_b};
      s2_hs  <= s1_hs;
    end
  end

  // The fall is predicted from the raw input so h_cnt is 0 while s1 holds the first low sample.
  assign fall_pending = !hsync && s1_hs;
  assign hs_fall      = !s1_hs && s2_hs;
  assign hs_rise      = s1_hs && !s2_hs;
  assign boundary     = hs_fall && !s1_vs && vs_last;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      h_prev  <= '0;
      v_cnt   <= '0;
      vs_last <= 1'b1;
    end else begin
      h_prev <= h_cnt;
      if (fall_pending)
        h_cnt <= '0;
      else if (h_cnt != HT)
        h_cnt <= h_cnt + 10'd1;
      if (hs_fall) begin
        vs_last <= s1_vs;
        if (boundary)
          v_cnt <= '0;
        else if (v_cnt != VT)
          v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  assign h_reach   = (h_cnt == HT) && (h_prev != HT);
  assign v_reach   = hs_fall && !boundary && (v_cnt == VT1);
  assign line_err  = (hs_fall && (h_prev != HT1)) || h_reach || (hs_rise && (h_cnt != HSW));
  assign frame_err = (boundary && (v_cnt != VT1)) || v_reach;
  assign err       = line_err || frame_err;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      state <= SEARCH;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SEARCH:  if (boundary) next_state = MEASURE;
      MEASURE: begin
        if (err)
          next_state = SEARCH;
        else if (boundary)
          next_state = LOCKED;
      end
      LOCKED:  if (err) next_state = SEARCH;
      default: next_state = SEARCH;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err_cnt     <= '0;
    end else begin
      locked      <= (next_state == LOCKED);
      // An errored boundary never counts as a locked frame start.
      frame_start <= boundary && !err && ((state == MEASURE) || (state == LOCKED));
      if ((state == LOCKED) && err && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

  assign h_act  = (h_cnt >= HA0) && (h_cnt <= HA1);
  assign v_act  = (v_cnt >= VA0) && (v_cnt <= VA1);
  assign active = (state == LOCKED) && h_act && v_act;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
      dec_x     <= '0;
      dec_y     <= '0;
      dec_rgb   <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
    end else begin
      dec_valid <= active;
      dec_x     <= active ? (h_cnt - HA0) : 10'd0;
      dec_y     <= active ? (v_cnt - VA0) : 10'd0;
      dec_rgb   <= active ? s1_rgb : 12'd0;
      pix_valid <= dec_valid;
      pix_x     <= dec_x;
      pix_y     <= dec_y;
      pix_data  <= dec_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`timescale 1ns/1ps
`default_nettype none
// tb_vga_capture: directed bench on a miniature VGA timing (10x6 total, 4x3 active).
module tb_vga_capture;

  localparam int HS = 2, HB = 2, HA = 4, HT = 10;
  localparam int VS = 1, VB = 1, VA = 3, VT = 6;
  localparam int NPIX = HA * VA;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        pix_valid, frame_start, locked;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_data;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit          h_act [3];
  bit          h_cap [3];
  bit          h_fs  [3];
  int          h_x   [3];
  int          h_y   [3];
  logic [11:0] h_rgb [3];

  int pix_seen, first_x, first_y, last_x, last_y;

  vga_capture #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      h_act[i] = 1'b0; h_cap[i] = 1'b0; h_fs[i] = 1'b0;
      h_x[i] = 0; h_y[i] = 0; h_rgb[i] = '0;
    end
  endtask

  // One pixel clock: check outputs due from earlier inputs, then drive the next input.
  task automatic cyc(input logic hs, input logic vs, input logic [11:0] rgb,
                     input bit act, input int x, input int y, input bit fs, input bit cap);
    logic        ev;
    logic [9:0]  ex, ey;
    logic [11:0] ed;
    @(negedge pclk);
    ev = h_act[2] && h_cap[2];
    ex = ev ? 10'(h_x[2]) : 10'd0;
    ey = ev ? 10'(h_y[2]) : 10'd0;
    ed = ev ? h_rgb[2] : 12'd0;
    chk("pix", 64'({pix_valid, pix_x, pix_y, pix_data}), 64'({ev, ex, ey, ed}));
    chk("frame_start", 64'(frame_start), 64'(h_fs[1]));
    if (pix_valid) begin
      if (pix_seen == 0) begin
        first_x = int'(pix_x);
        first_y = int'(pix_y);
      end
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      pix_seen++;
    end
    for (int i = 2; i > 0; i--) begin
      h_act[i] = h_act[i-1]; h_cap[i] = h_cap[i-1]; h_fs[i] = h_fs[i-1];
      h_x[i] = h_x[i-1]; h_y[i] = h_y[i-1]; h_rgb[i] = h_rgb[i-1];
    end
    h_act[0] = act; h_cap[0] = cap; h_fs[0] = fs;
    h_x[0] = x; h_y[0] = y; h_rgb[0] = rgb;
    hsync = hs;
    vsync = vs;
    {vga_r, vga_g, vga_b} = rgb;
  endtask

  task automatic send_line(input int len, input int sync, input int y, input bit fs, input bit cap);
    bit          act;
    int          x, yy;
    logic [11:0] rgb;
    for (int h = 0; h < len; h++) begin
      act = (y >= VS + VB) && (y < VS + VB + VA) && (h >= HS + HB) && (h < HS + HB + HA);
      x   = h - (HS + HB);
      yy  = y - (VS + VB);
      rgb = act ? {yy[5:0], x[5:0]} : 12'($urandom);
      cyc((h < sync) ? 1'b0 : 1'b1, (y < VS) ? 1'b0 : 1'b1, rgb, act, x, yy,
          fs && (h == 0), cap);
    end
  endtask

  task automatic send_frame(input int nlines, input bit fs, input bit cap,
                            input int long_y, input int short_y);
    pix_seen = 0;
    for (int y = 0; y < nlines; y++)
      send_line((y == long_y) ? HT + 1 : HT, (y == short_y) ? HS - 1 : HS, y,
                fs && (y == 0), cap);
  endtask

  initial begin
    clear_hist();
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_pix_xy", 64'({pix_x, pix_y}), 64'd0);
    chk("rst_pix_data", 64'(pix_data), 64'd0);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge pclk);
    #2 rst_n = 1'b1;

    // Short hsync pulse while measuring: back to search, no error counted.
    send_frame(VT, 1'b0, 1'b0, -1, 1);
    chk("meas_err_locked", 64'(locked), 64'd0);
    chk("meas_err_cnt", 64'(err_cnt), 64'd0);
    send_frame(VT, 1'b0, 1'b0, -1, -1);
    chk("measure_locked", 64'(locked), 64'd0);
    send_frame(VT, 1'b1, 1'b1, -1, -1);
    chk("lock_locked", 64'(locked), 64'd1);
    chk("lock_err_cnt", 64'(err_cnt), 64'd0);
    chk("lock_npix", 64'(pix_seen), 64'(NPIX));
    chk("first_pix", 64'({first_x[9:0], first_y[9:0]}), 64'd0);
    chk("last_pix", 64'({last_x[9:0], last_y[9:0]}), 64'({10'(HA - 1), 10'(VA - 1)}));

    // One line one clock too long while locked.
    send_frame(VT, 1'b1, 1'b0, 0, -1);
    chk("long_locked", 64'(locked), 64'd0);
    chk("long_err_cnt", 64'(err_cnt), 64'd1);
    chk("long_npix", 64'(pix_seen), 64'd0);
    send_frame(VT, 1'b0, 1'b0, -1, -1);
    chk("long_relock_meas", 64'(locked), 64'd0);
    send_frame(VT, 1'b1, 1'b1, -1, -1);
    chk("long_relocked", 64'(locked), 64'd1);
    chk("relock_npix", 64'(pix_seen), 64'(NPIX));

    // A frame one line short while locked: error lands on the next boundary.
    send_frame(VT - 1, 1'b1, 1'b1, -1, -1);
    chk("short_frame_still_locked", 64'(locked), 64'd1);
    send_frame(VT, 1'b0, 1'b0, -1, -1);
    chk("short_frame_err_cnt", 64'(err_cnt), 64'd2);
    chk("short_frame_locked", 64'(locked), 64'd0);
    send_frame(VT, 1'b0, 1'b0, -1, -1);
    send_frame(VT, 1'b1, 1'b1, -1, -1);
    chk("pre_reset_locked", 64'(locked), 64'd1);

    // Asynchronous reset in the middle of an active line.
    pix_seen = 0;
    send_line(HT, HS, 0, 1'b1, 1'b1);
    send_line(HT, HS, 1, 1'b0, 1'b1);
    send_line(HT, HS, 2, 1'b0, 1'b1);
    send_line(7, HS, 3, 1'b0, 1'b1);
    @(posedge pclk);
    #1 chk("pre_reset_valid", 64'(pix_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pix", 64'({pix_valid, pix_x, pix_y, pix_data}), 64'd0);
    chk("async_rst_frame_start", 64'(frame_start), 64'd0);
    chk("async_rst_locked", 64'(locked), 64'd0);
    chk("async_rst_err_cnt", 64'(err_cnt), 64'd0);
    clear_hist();
    cyc(1'b1, 1'b1, 12'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 12'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    send_line(HT, HS, 4, 1'b0, 1'b0);
    send_line(HT, HS, 5, 1'b0, 1'b0);
    send_frame(VT, 1'b0, 1'b0, -1, -1);
    chk("post_rst_measure", 64'(locked), 64'd0);
    send_frame(VT, 1'b1, 1'b1, -1, -1);
    chk("post_rst_locked", 64'(locked), 64'd1);
    chk("post_rst_npix", 64'(pix_seen), 64'(NPIX));

    // 300 locked errors: err_cnt saturates at 255.
    for (int i = 0; i < 300; i++) begin
      send_frame(VT - 1, 1'b1, 1'b1, -1, -1);
      send_frame(VT, 1'b0, 1'b0, -1, -1);
      send_frame(VT, 1'b0, 1'b0, -1, -1);
      if (i == 0)   chk("sat_err_1", 64'(err_cnt), 64'd1);
      if (i == 253) chk("sat_err_254", 64'(err_cnt), 64'd254);
      if (i == 254) chk("sat_err_255", 64'(err_cnt), 64'd255);
    end
    chk("sat_err_final", 64'(err_cnt), 64'd255);
    chk("sat_locked", 64'(locked), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
